// File: rtl/ofdm_seq_pkg.sv
// Shared types and constants for the TX chip-sequence generator.
// Sample levels are derived from the chip amplitude.
package ofdm_seq_pkg;

  localparam int SEQ_LEN    = 16;
  localparam int CHIP_IDX_W = $clog2(SEQ_LEN);
  localparam int REP_W      = 8;
  localparam int SAMP_W     = 8;
  localparam int AMP_DEF    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seqState_e;

  typedef logic signed [SAMP_W-1:0] sample_t;

  function automatic sample_t posSample(int amp);
    return sample_t'(amp);
  endfunction

  function automatic sample_t negSample(int amp);
    return sample_t'(-amp);
  endfunction

endpackage

// File: rtl/seq_chip_map.sv
// Maps one sign chip to a signed +/-AMP sample.
// Purely combinational; the parent owns the output register.
module seq_chip_map
  import ofdm_seq_pkg::*;
#(
  parameter int AMP = AMP_DEF
) (
  input  logic    chip,
  output sample_t sample
);

  localparam sample_t POS = posSample(AMP);
  localparam sample_t NEG = negSample(AMP);

  assign sample = chip ? NEG : POS;

endmodule

// File: rtl/seq_repeat_gen.sv
// Emits a 16-chip real/imag sign pattern as +/-AMP samples,
// LSB first, repeated REPEAT times per load.
module seq_repeat_gen
  import ofdm_seq_pkg::*;
#(
  parameter int REPEAT = 8,
  parameter int AMP    = AMP_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               inEn,
  input  logic [SEQ_LEN-1:0] patternR,
  input  logic [SEQ_LEN-1:0] patternI,
  output logic               ready,
  output logic               outEn,
  output logic [SAMP_W-1:0]  bitOutR,
  output logic [SAMP_W-1:0]  bitOutI,
  output logic               done
);

  localparam logic [CHIP_IDX_W-1:0] LAST_CHIP =
    CHIP_IDX_W'(SEQ_LEN - 1);
  localparam logic [REP_W-1:0] LAST_REP =
    REP_W'(REPEAT - 1);

  seqState_e stateQ, stateD;
  logic [SEQ_LEN-1:0] patRQ, patRD;
  logic [SEQ_LEN-1:0] patIQ, patID;
  logic [CHIP_IDX_W-1:0] chipQ, chipD;
  logic [REP_W-1:0] repQ, repD;
  logic load;
  logic sendD;
  logic lastD;
  sample_t sampR, sampI;

  // ready and done are registered, so done marks the last sample now shown
  always_comb begin
    stateD = stateQ;
    patRD  = patRQ;
    patID  = patIQ;
    chipD  = chipQ;
    repD   = repQ;
    load   = inEn & ready;
    if (load) begin
      stateD = SEND;
      patRD  = patternR;
      patID  = patternI;
      chipD  = '0;
      repD   = '0;
    end else if (done) begin
      stateD = IDLE;
      chipD  = '0;
      repD   = '0;
    end else if (stateQ == SEND) begin
      if (chipQ == LAST_CHIP) begin
        chipD = '0;
        repD  = repQ + 8'd1;
      end else begin
        chipD = chipQ + 1'b1;
      end
    end
    sendD = (stateD == SEND);
    lastD = sendD && (chipD == LAST_CHIP)
                  && (repD == LAST_REP);
  end

  seq_chip_map #(.AMP(AMP)) uMapR (
    .chip   (patRD[chipD]),
    .sample (sampR)
  );

  seq_chip_map #(.AMP(AMP)) uMapI (
    .chip   (patID[chipD]),
    .sample (sampI)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stateQ  <= IDLE;
      patRQ   <= '0;
      patIQ   <= '0;
      chipQ   <= '0;
      repQ    <= '0;
      ready   <= 1'b1;
      outEn   <= 1'b0;
      bitOutR <= '0;
      bitOutI <= '0;
      done    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      patRQ   <= patRD;
      patIQ   <= patID;
      chipQ   <= chipD;
      repQ    <= repD;
      ready   <= !sendD || lastD;
      outEn   <= sendD;
      bitOutR <= sendD ? sampR : '0;
      bitOutI <= sendD ? sampI : '0;
      done    <= lastD;
    end
  end

endmodule

// File: tb/tb_seq_repeat_gen.sv
// Random-stimulus bench for seq_repeat_gen against a queue-based
// model of the emitted burst, at default and corner parameters.
module tb_seq_repeat_gen;

  localparam int REP_A = 8;
  localparam int AMP_A = 64;
  localparam int REP_B = 1;
  localparam int AMP_B = 127;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic inEn = 1'b0;
  logic [15:0] patternR = '0;
  logic [15:0] patternI = '0;

  logic readyA, outEnA, doneA;
  logic [7:0] rA, iA;
  logic readyB, outEnB, doneB;
  logic [7:0] rB, iB;

  always #5 Clk = ~Clk;

  seq_repeat_gen #(.REPEAT(REP_A), .AMP(AMP_A)) dutA (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .inEn     (inEn),
    .patternR (patternR),
    .patternI (patternI),
    .ready    (readyA),
    .outEn    (outEnA),
    .bitOutR  (rA),
    .bitOutI  (iA),
    .done     (doneA)
  );

  seq_repeat_gen #(.REPEAT(REP_B), .AMP(AMP_B)) dutB (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .inEn     (inEn),
    .patternR (patternR),
    .patternI (patternI),
    .ready    (readyB),
    .outEn    (outEnB),
    .bitOutR  (rB),
    .bitOutI  (iB),
    .done     (doneB)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] i;
  } samp_t;

  samp_t pendA[$];
  samp_t pendB[$];
  samp_t curA, curB;
  bit vA, vB;

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] lvl(logic neg, int amp);
    return neg ? 8'(256 - amp) : 8'(amp);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A queue holds every sample still owed; a load is taken only
  // when nothing beyond the current sample remains.
  task automatic modelEdge();
    if (!Rst_n) begin
      pendA.delete();
      pendB.delete();
    end else if (inEn) begin
      if (pendA.size() == 0)
        for (int r = 0; r < REP_A; r++)
          for (int c = 0; c < 16; c++)
            pendA.push_back({lvl(patternR[c], AMP_A),
                             lvl(patternI[c], AMP_A)});
      if (pendB.size() == 0)
        for (int r = 0; r < REP_B; r++)
          for (int c = 0; c < 16; c++)
            pendB.push_back({lvl(patternR[c], AMP_B),
                             lvl(patternI[c], AMP_B)});
    end
    vA = pendA.size() > 0;
    curA = vA ? pendA.pop_front() : '0;
    vB = pendB.size() > 0;
    curB = vB ? pendB.pop_front() : '0;
  endtask

  task automatic step();
    @(posedge Clk);
    modelEdge();
    #1;
    chk("outEnA", 32'(outEnA), 32'(vA));
    chk("bitOutRA", 32'(rA), 32'(curA.r));
    chk("bitOutIA", 32'(iA), 32'(curA.i));
    chk("doneA", 32'(doneA), 32'(vA && pendA.size() == 0));
    chk("readyA", 32'(readyA), 32'(pendA.size() == 0));
    chk("outEnB", 32'(outEnB), 32'(vB));
    chk("bitOutRB", 32'(rB), 32'(curB.r));
    chk("bitOutIB", 32'(iB), 32'(curB.i));
    chk("doneB", 32'(doneB), 32'(vB && pendB.size() == 0));
    chk("readyB", 32'(readyB), 32'(pendB.size() == 0));
  endtask

  task automatic loadNew(logic [15:0] pr, logic [15:0] pi);
    patternR = pr;
    patternI = pi;
    inEn = 1'b1;
    step();
    inEn = 1'b0;
  endtask

  initial begin
    int cntA, cntB, dnA, dnB, n;

    repeat (3) step();
    Rst_n = 1'b1;
    repeat (20) step();

    loadNew(16'h0001, 16'hFFFE);
    cntA = int'(outEnA);
    cntB = int'(outEnB);
    dnA = int'(doneA);
    dnB = int'(doneB);
    repeat (140) begin
      step();
      cntA += int'(outEnA);
      cntB += int'(outEnB);
      dnA += int'(doneA);
      dnB += int'(doneB);
    end
    chk("burstLenA", 32'(cntA), 32'd128);
    chk("doneCntA", 32'(dnA), 32'd1);
    chk("burstLenB", 32'(cntB), 32'd16);
    chk("doneCntB", 32'(dnB), 32'd1);

    loadNew(16'($urandom), 16'($urandom));
    n = 0;
    while (!readyA && n < 200) begin
      step();
      n++;
    end
    chk("b2bWait", 32'(n < 200), 32'd1);
    loadNew(16'($urandom), 16'($urandom));
    cntA = int'(outEnA);
    repeat (140) begin
      step();
      cntA += int'(outEnA);
    end
    chk("b2bSecondLen", 32'(cntA), 32'd128);

    loadNew(16'($urandom), 16'($urandom));
    repeat (48) step();
    loadNew(16'hFFFF, 16'hFFFF);
    repeat (90) step();

    repeat (800) begin
      inEn = ($urandom_range(0, 19) == 0);
      patternR = 16'($urandom);
      patternI = 16'($urandom);
      step();
    end
    inEn = 1'b0;
    repeat (140) step();

    loadNew(16'($urandom), 16'($urandom));
    repeat (30) step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
